// File: rtl/par_mul_pkg.sv
// Shared types and elaboration-time helpers for the lane-split serial multiplier.
package par_mul_pkg;

  typedef enum logic [1:0] {IDLE, MUL, COMBINE, DONE} state_t;

  // Width of a counter that indexes 0..n-1; never narrower than 1 bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int slice_w(input int width, input int lanes);
    return width / lanes;
  endfunction

  function automatic int acc_w(input int width, input int lanes);
    return width + width / lanes;
  endfunction

endpackage

// File: rtl/par_mul_lane.sv
// One serial shift-add lane: multiplies the held multiplicand by its b slice, DIGIT bits per step.
module par_mul_lane
  import par_mul_pkg::*;
#(
  parameter int WIDTH = 1024,
  parameter int LANES = 4,
  parameter int DIGIT = 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   clear,
  input  logic                                   step,
  input  logic [WIDTH-1:0]                       a,
  input  logic [slice_w(WIDTH, LANES)-1:0]       bslice,
  output logic [acc_w(WIDTH, LANES)-1:0]         acc
);

  localparam int SLICE = slice_w(WIDTH, LANES);
  localparam int ACC_W = acc_w(WIDTH, LANES);

  // The multiplicand copy is pre-shifted each step, so no per-step shift amount is needed.
  logic [ACC_W-1:0] am;
  logic [SLICE-1:0] sr;

  always_ff @(posedge clk) begin
    if (rst) begin
      am  <= '0;
      sr  <= '0;
      acc <= '0;
    end else if (clear) begin
      am  <= ACC_W'(a);
      sr  <= bslice;
      acc <= '0;
    end else if (step) begin
      acc <= acc + am * ACC_W'(sr[DIGIT-1:0]);
      am  <= am << DIGIT;
      sr  <= sr >> DIGIT;
    end
  end

endmodule

// File: rtl/par_serial_mul.sv
// Handshaked lane-split serial multiplier with sequential lane combine.
// Optional PAR_MUL_ZERO_SKIP_EN: zero operands bypass MUL/COMBINE straight to DONE.
module par_serial_mul
  import par_mul_pkg::*;
#(
  parameter int WIDTH = 1024,
  parameter int LANES = 4,
  parameter int DIGIT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);

  localparam int SLICE = slice_w(WIDTH, LANES);
  localparam int STEPS = SLICE / DIGIT;
  localparam int ACC_W = acc_w(WIDTH, LANES);
  localparam int CNT_W = clog2(STEPS);
  localparam int IDX_W = clog2(LANES);
  localparam int P_W   = 2 * WIDTH;

  if (WIDTH % LANES != 0) begin : g_bad_lanes
    $error("par_serial_mul: WIDTH must be a multiple of LANES");
  end
  if (SLICE % DIGIT != 0) begin : g_bad_digit
    $error("par_serial_mul: WIDTH/LANES must be a multiple of DIGIT");
  end

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic             clear, step;
  logic [ACC_W-1:0] acc [LANES];

  // Operands are captured inside the lanes on clear; the top keeps no copy of a or b.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    par_mul_lane #(
      .WIDTH(WIDTH),
      .LANES(LANES),
      .DIGIT(DIGIT)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .clear (clear),
      .step  (step),
      .a     (a),
      .bslice(b[k*SLICE +: SLICE]),
      .acc   (acc[k])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    clear     = 1'b0;
    step      = 1'b0;
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    case (state)
      IDLE: begin
        if (in_valid) begin
          clear    = 1'b1;
          state_nx = MUL;
`ifdef PAR_MUL_ZERO_SKIP_EN
          if ((a == '0) || (b == '0)) state_nx = DONE;
`endif
        end
      end
      MUL: begin
        step = 1'b1;
        if (cnt == CNT_W'(STEPS - 1)) state_nx = COMBINE;
      end
      COMBINE: begin
        if (idx == IDX_W'(LANES - 1)) state_nx = DONE;
      end
      DONE: begin
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      idx     <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            cnt     <= '0;
            idx     <= '0;
            product <= '0;
          end
        end
        MUL: cnt <= cnt + CNT_W'(1);
        COMBINE: begin
          product <= product + (P_W'(acc[idx]) << (idx * SLICE));
          idx     <= idx + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_par_serial_mul.sv
// Scoreboard bench for par_serial_mul: three configurations (16/4/1, defaults, DIGIT=4) on one clock.
module tb_par_serial_mul;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          iv  [3];
  logic          orr [3];
  logic [1023:0] av  [3];
  logic [1023:0] bv  [3];

  logic          ir0, ir1, ir2, ov0, ov1, ov2;
  logic [31:0]   p0;
  logic [2047:0] p1, p2;

  int total = 0;
  int bad   = 0;
  logic [2047:0] sb [$];

  par_serial_mul #(.WIDTH(16), .LANES(4), .DIGIT(1)) u_s (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir0), .a(av[0][15:0]), .b(bv[0][15:0]),
    .out_valid(ov0), .out_ready(orr[0]), .product(p0));

  par_serial_mul #(.WIDTH(1024), .LANES(4), .DIGIT(1)) u_l (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir1), .a(av[1]), .b(bv[1]),
    .out_valid(ov1), .out_ready(orr[1]), .product(p1));

  par_serial_mul #(.WIDTH(1024), .LANES(4), .DIGIT(4)) u_d (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir2), .a(av[2]), .b(bv[2]),
    .out_valid(ov2), .out_ready(orr[2]), .product(p2));

  function automatic logic get_ov(input int u);
    case (u)
      0:       return ov0;
      1:       return ov1;
      default: return ov2;
    endcase
  endfunction

  function automatic logic get_ir(input int u);
    case (u)
      0:       return ir0;
      1:       return ir1;
      default: return ir2;
    endcase
  endfunction

  function automatic logic [2047:0] get_p(input int u);
    case (u)
      0:       return 2048'(p0);
      1:       return p1;
      default: return p2;
    endcase
  endfunction

  function automatic logic [1023:0] mask_op(input int u, input logic [1023:0] x);
    return (u == 0) ? (x & 1024'hFFFF) : x;
  endfunction

  // Edges after acceptance until out_valid is seen: STEPS+LANES on the normal path.
  function automatic int exp_lat(input int u, input logic [1023:0] x, input logic [1023:0] y);
    int base;
    base = (u == 0) ? 8 : (u == 1) ? 260 : 68;
`ifdef PAR_MUL_ZERO_SKIP_EN
    if (mask_op(u, x) == '0 || mask_op(u, y) == '0) base = 0;
`else
    if (x === 'x || y === 'x) base = -1;
`endif
    return base;
  endfunction

  function automatic logic [1023:0] rand_wide();
    logic [1023:0] r;
    for (int i = 0; i < 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  task automatic do_op(input int u, input logic [1023:0] x, input logic [1023:0] y, input int stall);
    logic [1023:0] xm, ym;
    logic [2047:0] e, held, got;
    int lat, want;
    xm = mask_op(u, x);
    ym = mask_op(u, y);
    want = exp_lat(u, x, y);
    sb.push_back({1024'b0, xm} * {1024'b0, ym});
    av[u] = x;
    bv[u] = y;
    iv[u] = 1'b1;
    total++;
    if (get_ir(u) !== 1'b1) begin
      bad++;
      $display("FAIL accept_ready unit=%0d got=%b want=1", u, get_ir(u));
    end
    @(posedge clk); #1;
    iv[u] = 1'b0;
    av[u] = ~x;
    bv[u] = ~y;
    lat = 0;
    while (get_ov(u) !== 1'b1 && lat < 2000) begin
      total++;
      if (get_ir(u) !== 1'b0) begin
        bad++;
        $display("FAIL busy_ready unit=%0d cyc=%0d got=%b want=0", u, lat, get_ir(u));
      end
      @(posedge clk); #1;
      lat++;
    end
    total++;
    if (lat != want) begin
      bad++;
      $display("FAIL latency unit=%0d got=%0d want=%0d", u, lat, want);
    end
    if (get_ov(u) !== 1'b1) begin
      void'(sb.pop_front());
      return;
    end
    held = get_p(u);
    repeat (stall) begin
      orr[u] = 1'b0;
      @(posedge clk); #1;
      total++;
      if (get_ov(u) !== 1'b1 || get_ir(u) !== 1'b0 || get_p(u) !== held) begin
        bad++;
        $display("FAIL hold unit=%0d ov=%b ir=%b stable=%b want ov=1 ir=0 stable=1",
                 u, get_ov(u), get_ir(u), get_p(u) === held);
      end
    end
    orr[u] = 1'b1;
    e   = sb.pop_front();
    got = get_p(u);
    total++;
    if (got !== e) begin
      bad++;
      $display("FAIL product unit=%0d got hi=%h lo=%h want hi=%h lo=%h",
               u, got[2047:1984], got[63:0], e[2047:1984], e[63:0]);
    end
    @(posedge clk); #1;
    orr[u] = 1'b0;
    total++;
    if (get_ov(u) !== 1'b0 || get_ir(u) !== 1'b1) begin
      bad++;
      $display("FAIL release unit=%0d ov=%b ir=%b want ov=0 ir=1", u, get_ov(u), get_ir(u));
    end
  endtask

  task automatic check_idle(input string tag, input int u);
    total++;
    if (get_ov(u) !== 1'b0 || get_ir(u) !== 1'b1 || get_p(u) !== '0) begin
      bad++;
      $display("FAIL %s unit=%0d ov=%b ir=%b prod_zero=%b want ov=0 ir=1 prod_zero=1",
               tag, u, get_ov(u), get_ir(u), get_p(u) === '0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < 3; u++) check_idle("reset", u);
    rst = 1'b0;
    @(posedge clk); #1;
    for (int u = 0; u < 3; u++) check_idle("post_reset", u);
  endtask

  task automatic test_small_max();
    do_op(0, 1024'hFFFF, 1024'hFFFF, 0);
    do_op(0, 1024'h0001, 1024'hFFFF, 0);
    do_op(0, 1024'hA5A5, 1024'h5A5A, 0);
  endtask

  task automatic test_wide_pow();
    logic [1023:0] t;
    t = '0;
    t[1023] = 1'b1;
    do_op(1, t, t, 0);
    do_op(1, '1, '1, 0);
  endtask

  task automatic test_backpressure();
    do_op(0, 1024'h1234, 1024'h5678, 10);
  endtask

  task automatic test_reset_mid();
    av[1] = rand_wide();
    bv[1] = rand_wide();
    iv[1] = 1'b1;
    @(posedge clk); #1;
    iv[1] = 1'b0;
    repeat (99) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_idle("mid_reset", 1);
    do_op(1, 1024'd3, 1024'd5, 0);
  endtask

  task automatic test_zero_skip();
    do_op(1, 1024'd0, 1024'h1234, 0);
    do_op(0, 1024'h4321, 1024'd0, 2);
  endtask

  task automatic test_random();
    logic [1023:0] x, y;
    for (int i = 0; i < 250; i++) begin
      x = rand_wide();
      y = rand_wide();
      case ($urandom_range(0, 9))
        0:       x = '1;
        1:       y = '1;
        2:       x = '0;
        3:       y = 1024'(1) << $urandom_range(0, 1023);
        default: ;
      endcase
      do_op(2, x, y, $urandom_range(0, 3));
    end
  endtask

  initial begin
    for (int u = 0; u < 3; u++) begin
      iv[u]  = 1'b0;
      orr[u] = 1'b0;
      av[u]  = '0;
      bv[u]  = '0;
    end
    rst = 1'b1;
    test_reset();
    test_small_max();
    test_wide_pow();
    test_backpressure();
    test_reset_mid();
    test_zero_skip();
    test_random();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_empty got=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
